// File: rtl/scan_unload_ctrl.sv
// scan_unload_ctrl: scan-chain initiator that unloads a CHAIN_LEN-bit DUT scan
// register into a parallel word while shifting back either the unloaded value
// (restore) or a supplied pattern (load).
// Optional feature macro: SCAN_UNLOAD_PARITY_EN adds rsp_parity, the XOR of all
// scan_sout bits captured in the current operation.
module scan_unload_ctrl #(
   parameter int unsigned CHAIN_LEN = 32,
   parameter int unsigned CNT_W     = 6
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_restore,
   input  logic [CHAIN_LEN-1:0] req_pattern,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [CHAIN_LEN-1:0] rsp_data,
`ifdef SCAN_UNLOAD_PARITY_EN
   output logic                 rsp_parity,
`endif
   output logic                 scan_sen,
   output logic                 scan_ce,
   output logic                 scan_sin,
   input  logic                 scan_sout,
   output logic                 busy
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      SHIFT = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t               state;
   logic [CNT_W-1:0]     count;
   logic                 restore_q;
   logic [CHAIN_LEN-1:0] pat_q;

   // Scan-in follows sout directly in restore mode; gated so it idles low outside SHIFT.
   assign scan_sin = (state == SHIFT) & (restore_q ? scan_sout : pat_q[CHAIN_LEN-1]);

   // Controller FSM with registered handshake and scan-pin outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         count     <= '0;
         restore_q <= 1'b0;
         pat_q     <= '0;
         rsp_data  <= '0;
         rsp_valid <= 1'b0;
         scan_sen  <= 1'b0;
         scan_ce   <= 1'b0;
         busy      <= 1'b0;
         req_ready <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  restore_q <= req_restore;
                  pat_q     <= req_pattern;
                  scan_sen  <= 1'b1;
                  busy      <= 1'b1;
                  req_ready <= 1'b0;
                  state     <= SETUP;
               end
            end
            SETUP: begin
               count   <= '0;
               scan_ce <= 1'b1;
               state   <= SHIFT;
            end
            SHIFT: begin
               rsp_data <= {rsp_data[CHAIN_LEN-2:0], scan_sout};
               pat_q    <= {pat_q[CHAIN_LEN-2:0], 1'b0};
               count    <= count + CNT_W'(1);
               if (count == LAST_CNT) begin
                  scan_sen  <= 1'b0;
                  scan_ce   <= 1'b0;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SCAN_UNLOAD_PARITY_EN
   // Running XOR of captured scan-out bits, cleared at the start of each operation.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rsp_parity <= 1'b0;
      end else if (state == SETUP) begin
         rsp_parity <= 1'b0;
      end else if (state == SHIFT) begin
         rsp_parity <= rsp_parity ^ scan_sout;
      end
   end
`endif

endmodule
